// File: rtl/ifm_skew_if.sv
// ifm_skew_if: IFM SRAM read stream into the feeder and the skewed row feed out of it
interface ifm_skew_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SYS_ROWS = 16
);
  logic read_en;
  logic [4:0] size;
  logic [DATA_WIDTH-1:0] ifm_rdata;
  logic clear;
  logic [SYS_ROWS*DATA_WIDTH-1:0] ifm_data;
  logic [SYS_ROWS-1:0] ifm_valid;
  logic col_done;
  logic [15:0] col_cnt;
  modport master (
    output read_en, size, ifm_rdata, clear,
    input ifm_data, ifm_valid, col_done, col_cnt
  );
  modport slave (
    input read_en, size, ifm_rdata, clear,
    output ifm_data, ifm_valid, col_done, col_cnt
  );
endinterface

// File: rtl/ifm_skew_feeder.sv
// ifm_skew_feeder: packs IFM read words into columns and feeds them diagonally skewed to the array rows
module ifm_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int SYS_ROWS = 16,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic rst_n,
  ifm_skew_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(SYS_ROWS + 1);
  logic [RD_LATENCY-1:0] rd_pipe;
  logic rd_valid;
  logic [SW-1:0] wr_idx, size_q, size_clamp, eff_size;
  logic last;
  logic [DW-1:0] pack_buf [SYS_ROWS];
  logic [DW-1:0] col_reg [SYS_ROWS];
  logic [SYS_ROWS-1:0] col_vld;
  logic col_done_q;
  logic [15:0] col_cnt_q;
  assign rd_valid = rd_pipe[RD_LATENCY-1];
  assign size_clamp = (bus.size == 5'd0 || int'(bus.size) > SYS_ROWS) ? SW'(SYS_ROWS) : SW'(bus.size);
  // a column's size is only sampled with its first word
  assign eff_size = (wr_idx == '0) ? size_clamp : size_q;
  assign last = rd_valid && (wr_idx == eff_size - SW'(1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe <= '0;
      wr_idx <= '0;
      size_q <= '0;
      col_vld <= '0;
      col_done_q <= 1'b0;
      col_cnt_q <= '0;
      for (int l = 0; l < SYS_ROWS; l++) begin
        pack_buf[l] <= '0;
        col_reg[l] <= '0;
      end
    end else begin
      for (int k = RD_LATENCY - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
      rd_pipe[0] <= bus.read_en;
      col_done_q <= !bus.clear && last;
      col_vld <= '0;
      for (int l = 0; l < SYS_ROWS; l++) col_reg[l] <= '0;
      if (bus.clear) begin
        wr_idx <= '0;
      end else if (rd_valid) begin
        for (int l = 0; l < SYS_ROWS; l++) if (wr_idx == SW'(l)) pack_buf[l] <= bus.ifm_rdata;
        if (wr_idx == '0) size_q <= size_clamp;
        wr_idx <= last ? '0 : wr_idx + SW'(1);
        if (last) begin
          col_cnt_q <= col_cnt_q + 16'd1;
          for (int l = 0; l < SYS_ROWS; l++) begin
            col_vld[l] <= SW'(l) < eff_size;
            col_reg[l] <= (SW'(l) == wr_idx) ? bus.ifm_rdata : (SW'(l) < eff_size ? pack_buf[l] : '0);
          end
        end
      end
    end
  end
  assign bus.col_done = col_done_q;
  assign bus.col_cnt = col_cnt_q;
  assign bus.ifm_valid[0] = col_vld[0];
  assign bus.ifm_data[0 +: DW] = col_reg[0];
  // lane i trails col_reg by i registers; invalid slots carry zero data
  for (genvar i = 1; i < SYS_ROWS; i++) begin : g_lane
    logic [DW:0] dl [i];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < i; k++) dl[k] <= '0;
      end else begin
        dl[0] <= {col_vld[i], col_reg[i]};
        for (int k = 1; k < i; k++) dl[k] <= dl[k-1];
      end
    end
    assign bus.ifm_valid[i] = dl[i-1][DW];
    assign bus.ifm_data[i*DW +: DW] = dl[i-1][DW-1:0];
  end
endmodule
